fetch_unit_pipelined: RTL and testbench
=======================================

Name: fetch_unit_pipelined

Overview:
Parametrised instruction-fetch stage for the pipelined successor of the 64-bit single-cycle CPU. It owns the program counter and drives the combinational instruction memory. It resolves branch redirects (conditional, unconditional, register), handles stall and flush, and registers the fetched instruction into an IF/ID pipeline register with a valid bit. It also keeps fetch and flush performance counters.

Parameters:
ADDR_W, 64, width of PC and all address ports.
INSTR_W, 32, instruction width.
COND_W, 19, width of the conditional-branch word offset.
UNCOND_W, 26, width of the unconditional-branch word offset.
RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
stall  in  1  hold PC and IF/ID register.
br_taken  in  1  redirect request from the decode/execute stage.
br_uncond  in  1  1 = use UNCOND_W offset, 0 = use COND_W offset.
br_reg  in  1  1 = register-indirect target (overrides the offset select).
br_pc  in  ADDR_W  PC of the branch instruction.
br_cond_off  in  COND_W  signed word offset.
br_uncond_off  in  UNCOND_W  signed word offset.
br_reg_target  in  ADDR_W  register target for BR.
imem_addr  out  ADDR_W  equals pc; instruction memory is combinational.
imem_instr  in  INSTR_W  instruction at imem_addr, valid in the same cycle.
pc  out  ADDR_W  current PC.
if_id_instr  out  INSTR_W  registered instruction.
if_id_pc  out  ADDR_W  PC of if_id_instr.
if_id_valid  out  1  IF/ID entry is a real instruction.
misalign  out  1  registered one-cycle pulse: register target had bits [1:0] != 0.
fetch_cnt  out  CNT_W  count of instructions accepted into IF/ID.
flush_cnt  out  CNT_W  count of redirects taken.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC; if_id_valid=0; if_id_instr=0; if_id_pc=0; misalign=0; both counters=0. Deassertion is sampled at the clock; the first fetch is RESET_PC on the first edge after release.
- Target arithmetic, all mod 2^ADDR_W:
  - cond: br_pc + (sign_extend(br_cond_off) << 2).
  - uncond: br_pc + (sign_extend(br_uncond_off) << 2).
  - reg: {br_reg_target[ADDR_W-1:2], 2'b00}.
  - Sign extension is to ADDR_W. Overflow wraps silently.
- Per-edge priority is redirect > stall > advance.
- Redirect (br_taken=1, stall ignored):
  - pc <= target.
  - if_id_valid <= 0 (flushes the wrong-path instruction; if_id_instr/if_id_pc may update but are don't-care).
  - flush_cnt += 1.
  - misalign <= br_reg & (br_reg_target[1:0] != 0).
- Stall (stall=1, br_taken=0): pc, if_id_* and fetch_cnt hold; misalign <= 0.
- Advance (both 0):
  - pc <= pc + 4.
  - if_id_instr <= imem_instr; if_id_pc <= pc; if_id_valid <= 1.
  - fetch_cnt += 1.
  - misalign <= 0.
- Latency: an instruction at address A appears on if_id_* one edge after pc==A with no stall or redirect. A redirect costs exactly one bubble: if_id_valid=0 for one cycle, and the target instruction is valid on the second edge.
- Simultaneous redirect and stall: the redirect wins, since decode must not stall a squashed path.
- PC wrap: pc = 2^ADDR_W-4 advances to 0 with no flag.
- Counters are free-running and wrap at 2^CNT_W, so all-ones + 1 = 0.
- Back-to-back redirects on consecutive edges are each taken; if_id_valid stays 0 and flush_cnt increments each cycle.
- Reset asserted mid-stall or mid-redirect forces the reset values immediately, regardless of clock.
- pc and imem_addr are always equal, including during reset.

Test Plan:
1. Release reset with RESET_PC=0 and imem returning 0x8B020020 at 0, 0x91000421 at 4 → if_id_pc=0/4 on edges 1/2, if_id_valid=1, fetch_cnt=2, pc=8.
2. At pc=0x40, stall=1 for 3 cycles → pc stays 0x40, if_id_* held, fetch_cnt unchanged. On release, pc=0x44 after 1 edge.
3. br_taken=1, br_uncond=0, br_pc=0x100, br_cond_off=19'h7FFFE (-2) → pc=0xF8, if_id_valid=0 for one cycle, flush_cnt+1, then if_id_pc=0xF8 valid.
4. br_taken=1 with stall=1, br_uncond=1, br_pc=0x0, br_uncond_off=26'h0000010 → pc=0x40, if_id_valid=0. Redirect wins over stall.
5. br_reg=1, br_reg_target=0x1003 → pc=0x1000, misalign=1 for exactly one cycle.
6. Force pc to 2^64-4 (branch with br_reg_target=0xFFFF_FFFF_FFFF_FFFC), then advance → pc=0. Assert reset mid-stall → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/fetch_unit_pipelined.sv
// Instruction-fetch stage for the pipelined 64-bit CPU.
// Holds the program counter and drives the combinational instruction memory.
// Resolves conditional, unconditional and register-indirect redirects.
// Registers the fetched instruction into the IF/ID register with a valid bit.
// Keeps free-running fetch and flush counters.
module fetch_unit_pipelined #(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned COND_W   = 19,
    parameter int unsigned UNCOND_W = 26,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                br_taken,
    input  logic                br_uncond,
    input  logic                br_reg,
    input  logic [ADDR_W-1:0]   br_pc,
    input  logic [COND_W-1:0]   br_cond_off,
    input  logic [UNCOND_W-1:0] br_uncond_off,
    input  logic [ADDR_W-1:0]   br_reg_target,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic                if_id_valid,
    output logic                misalign,
    output logic [CNT_W-1:0]    fetch_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    // Action taken on the next clock edge.
    // A redirect wins over a stall because decode must not hold a squashed path.
    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_STALL,
        ACT_REDIRECT
    } fetch_act_t;

    fetch_act_t        act;
    logic [ADDR_W-1:0] cond_off_ext;
    logic [ADDR_W-1:0] uncond_off_ext;
    logic [ADDR_W-1:0] cond_target;
    logic [ADDR_W-1:0] uncond_target;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] br_target;
    logic              reg_misaligned;

    // The instruction memory is addressed directly by the current PC.
    assign imem_addr = pc;

    // Sign-extend the word offsets to address width.
    always_comb begin
        cond_off_ext   = {{(ADDR_W-COND_W){br_cond_off[COND_W-1]}}, br_cond_off};
        uncond_off_ext = {{(ADDR_W-UNCOND_W){br_uncond_off[UNCOND_W-1]}}, br_uncond_off};
    end

    // Candidate targets; all arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        cond_target    = br_pc + (cond_off_ext << 2);
        uncond_target  = br_pc + (uncond_off_ext << 2);
        reg_target     = {br_reg_target[ADDR_W-1:2], 2'b00};
        reg_misaligned = (br_reg_target[1:0] != 2'b00);
    end

    // Register-indirect overrides the offset select.
    always_comb begin
        br_target = cond_target;
        if (br_reg) begin
            br_target = reg_target;
        end else if (br_uncond) begin
            br_target = uncond_target;
        end
    end

    // Per-edge priority: redirect, then stall, then advance.
    always_comb begin
        act = ACT_ADVANCE;
        if (br_taken) begin
            act = ACT_REDIRECT;
        end else if (stall) begin
            act = ACT_STALL;
        end
    end

    // Program counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            case (act)
                ACT_REDIRECT: pc <= br_target;
                ACT_ADVANCE:  pc <= pc + ADDR_W'(4);
                default:      pc <= pc;
            endcase
        end
    end

    // IF/ID pipeline register; a redirect squashes the wrong-path entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else begin
            case (act)
                ACT_REDIRECT: begin
                    if_id_valid <= 1'b0;
                end
                ACT_ADVANCE: begin
                    if_id_instr <= imem_instr;
                    if_id_pc    <= pc;
                    if_id_valid <= 1'b1;
                end
                default: begin
                    if_id_valid <= if_id_valid;
                end
            endcase
        end
    end

    // One-cycle pulse flagging a register target with nonzero low bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= (act == ACT_REDIRECT) && br_reg && reg_misaligned;
        end
    end

    // Free-running performance counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (act == ACT_ADVANCE) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (act == ACT_REDIRECT) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit_pipelined.sv
// Directed testbench for fetch_unit_pipelined with hand-computed expectations.
module tb_fetch_unit_pipelined;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic        br_uncond;
    logic        br_reg;
    logic [63:0] br_pc;
    logic [18:0] br_cond_off;
    logic [25:0] br_uncond_off;
    logic [63:0] br_reg_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] pc;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic        misalign;
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    int total;
    int bad;

    fetch_unit_pipelined #(
        .ADDR_W   (64),
        .INSTR_W  (32),
        .COND_W   (19),
        .UNCOND_W (26),
        .RESET_PC (64'h0),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_uncond     (br_uncond),
        .br_reg        (br_reg),
        .br_pc         (br_pc),
        .br_cond_off   (br_cond_off),
        .br_uncond_off (br_uncond_off),
        .br_reg_target (br_reg_target),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .misalign      (misalign),
        .fetch_cnt     (fetch_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents.
    function automatic logic [31:0] mem(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B02_0020;
        if (a == 64'h4) return 32'h9100_0421;
        return a[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    always_comb imem_instr = mem(imem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [63:0] e_pc, input logic e_valid,
                             input logic [63:0] e_ifpc, input logic [31:0] e_fetch,
                             input logic [31:0] e_flush);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".imem_addr"}, imem_addr, e_pc);
        chk({tag, ".valid"}, 64'(if_id_valid), 64'(e_valid));
        if (e_valid) chk({tag, ".if_id_pc"}, if_id_pc, e_ifpc);
        chk({tag, ".fetch_cnt"}, 64'(fetch_cnt), 64'(e_fetch));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(e_flush));
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        stall = 1'b0;
        br_taken = 1'b0;
        br_uncond = 1'b0;
        br_reg = 1'b0;
        br_pc = '0;
        br_cond_off = '0;
        br_uncond_off = '0;
        br_reg_target = '0;

        // Reset state
        #2;
        chk("rst.pc", pc, 64'h0);
        chk("rst.imem_addr", imem_addr, 64'h0);
        chk("rst.valid", 64'(if_id_valid), 64'h0);
        chk("rst.if_id_instr", 64'(if_id_instr), 64'h0);
        chk("rst.if_id_pc", if_id_pc, 64'h0);
        chk("rst.misalign", 64'(misalign), 64'h0);
        chk("rst.fetch_cnt", 64'(fetch_cnt), 64'h0);
        chk("rst.flush_cnt", 64'(flush_cnt), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // First two fetches
        step();
        chk_state("e1", 64'h4, 1'b1, 64'h0, 32'd1, 32'd0);
        chk("e1.instr", 64'(if_id_instr), 64'h8B02_0020);
        step();
        chk_state("e2", 64'h8, 1'b1, 64'h4, 32'd2, 32'd0);
        chk("e2.instr", 64'(if_id_instr), 64'h9100_0421);

        // Advance to pc=0x40
        repeat (14) step();
        chk_state("at40", 64'h40, 1'b1, 64'h3C, 32'd16, 32'd0);

        // Stall for three cycles
        stall = 1'b1;
        repeat (3) begin
            step();
            chk_state("stall", 64'h40, 1'b1, 64'h3C, 32'd16, 32'd0);
            chk("stall.instr", 64'(if_id_instr), 64'(32'h3C ^ 32'h5A5A_5A5A));
            chk("stall.misalign", 64'(misalign), 64'h0);
        end
        stall = 1'b0;
        step();
        chk_state("unstall", 64'h44, 1'b1, 64'h40, 32'd17, 32'd0);

        // Conditional branch, negative offset: 0x100 - 8 = 0xF8
        br_taken = 1'b1;
        br_uncond = 1'b0;
        br_pc = 64'h100;
        br_cond_off = 19'h7FFFE;
        step();
        chk_state("cond", 64'hF8, 1'b0, 64'h0, 32'd17, 32'd1);
        br_taken = 1'b0;
        step();
        chk_state("cond.tgt", 64'hFC, 1'b1, 64'hF8, 32'd18, 32'd1);
        chk("cond.instr", 64'(if_id_instr), 64'(32'hF8 ^ 32'h5A5A_5A5A));

        // Unconditional branch together with stall: redirect wins
        br_taken = 1'b1;
        stall = 1'b1;
        br_uncond = 1'b1;
        br_pc = 64'h0;
        br_uncond_off = 26'h0000010;
        step();
        chk_state("uncond", 64'h40, 1'b0, 64'h0, 32'd18, 32'd2);
        br_taken = 1'b0;
        stall = 1'b0;
        step();
        chk_state("uncond.tgt", 64'h44, 1'b1, 64'h40, 32'd19, 32'd2);

        // Register target with low bits set; br_reg overrides uncond select
        br_taken = 1'b1;
        br_reg = 1'b1;
        br_uncond = 1'b1;
        br_uncond_off = 26'h0000100;
        br_reg_target = 64'h1003;
        step();
        chk_state("reg", 64'h1000, 1'b0, 64'h0, 32'd19, 32'd3);
        chk("reg.misalign", 64'(misalign), 64'h1);

        // Back-to-back redirect; misalign drops after one cycle
        br_reg = 1'b0;
        br_uncond = 1'b0;
        br_pc = 64'h2000;
        br_cond_off = 19'h00003;
        step();
        chk_state("b2b", 64'h200C, 1'b0, 64'h0, 32'd19, 32'd4);
        chk("b2b.misalign", 64'(misalign), 64'h0);

        // Register target at the top of the address space, then wrap
        br_reg = 1'b1;
        br_reg_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        chk_state("top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 32'd19, 32'd5);
        chk("top.misalign", 64'(misalign), 64'h0);
        br_taken = 1'b0;
        br_reg = 1'b0;
        step();
        chk_state("wrap", 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'd20, 32'd5);
        step();
        chk_state("wrap2", 64'h4, 1'b1, 64'h0, 32'd21, 32'd5);
        chk("wrap2.instr", 64'(if_id_instr), 64'h8B02_0020);

        // Reset asserted mid-stall takes effect before the next edge
        stall = 1'b1;
        step();
        chk_state("prerst", 64'h4, 1'b1, 64'h0, 32'd21, 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.pc", pc, 64'h0);
        chk("arst.imem_addr", imem_addr, 64'h0);
        chk("arst.valid", 64'(if_id_valid), 64'h0);
        chk("arst.if_id_instr", 64'(if_id_instr), 64'h0);
        chk("arst.if_id_pc", if_id_pc, 64'h0);
        chk("arst.fetch_cnt", 64'(fetch_cnt), 64'h0);
        chk("arst.flush_cnt", 64'(flush_cnt), 64'h0);
        step();
        chk("arst.hold.pc", pc, 64'h0);
        chk("arst.hold.fetch", 64'(fetch_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
